present_spawner: RTL

//  Initiator side of the falling-present path: decides when a present appears and loads the

---
 rtl/present_spawner.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/present_spawner.sv
// present_spawner: decides when a present appears at a bubble-pop location, loads the
// trajectory mover, and tracks the present through falling, landed and blinking until retired.
module present_spawner #(
   parameter int         PRESENT_WIDTH = 20,
   parameter int         FLOOR_Y       = 459,
   parameter int         INIT_LIFT     = 64,
   parameter logic [8:0] SPAWN_THRESH  = 9'd64,
   parameter int         LINGER_FRAMES = 90,
   parameter int         BLINK_FRAMES  = 60,
   parameter int         BLINK_PERIOD  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        spawnTrigger,
   input  logic [10:0] popX,
   input  logic [10:0] popY,
   input  logic [10:0] presentTopLeftY,
   input  logic        presentCollected,
   output logic        loadN,
   output logic [10:0] initialX,
   output logic [10:0] initialY,
   output logic [15:0] initialYspeed,
   output logic        presentVisible,
   output logic [1:0]  presentType,
   output logic        collectedPulse,
   output logic        landed,
   output logic        busy
);

   localparam logic [10:0] X_MAX      = 11'(639 - PRESENT_WIDTH);
   localparam logic [10:0] Y_MAX      = 11'(FLOOR_Y - 1);
   localparam logic [10:0] FLOOR_LINE = 11'(FLOOR_Y);
   localparam logic [15:0] LIFT_SPEED = 16'(-INIT_LIFT);
   localparam logic [7:0]  LINGER_C   = 8'(LINGER_FRAMES);
   localparam logic [7:0]  BLINK_C    = 8'(BLINK_FRAMES);
   localparam logic [7:0]  PERIOD_C   = 8'(BLINK_PERIOD);
   localparam logic [7:0]  LFSR_SEED  = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_FALLING = 3'd2,
      ST_LANDED  = 3'd3,
      ST_BLINK   = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  lfsr_r;
   logic [7:0]  linger_r, linger_s;
   logic [7:0]  blink_r, blink_s;
   logic [7:0]  phase_r, phase_s;
   logic        spawn_ok_s;
   logic        alive_s;
   logic        loadn_s, visible_s, landed_s, busy_s, collected_s;
   logic [10:0] init_x_s, init_y_s;
   logic [15:0] init_speed_s;
   logic [1:0]  type_s;

   // x^8+x^6+x^5+x^4+1; an upset into the lock-up state re-seeds instead of sticking at zero
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic fb;
      fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      if (v == 8'h00) begin
         lfsr_step = LFSR_SEED;
      end else begin
         lfsr_step = {v[6:0], fb};
      end
   endfunction

   assign spawn_ok_s = ({1'b0, lfsr_r} < SPAWN_THRESH);
   assign alive_s    = (state_r == ST_FALLING) || (state_r == ST_LANDED) || (state_r == ST_BLINK);

   // Free-running spawn/type randomizer
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: collection beats landing, landing beats frame-counter expiry
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (spawnTrigger && spawn_ok_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_s = ST_FALLING;
         end
         ST_FALLING: begin
            if (presentCollected) begin
               state_s = ST_IDLE;
            end else if (presentTopLeftY >= FLOOR_LINE) begin
               state_s = ST_LANDED;
            end else begin
               state_s = ST_FALLING;
            end
         end
         ST_LANDED: begin
            if (presentCollected) begin
               state_s = ST_IDLE;
            end else if (startOfFrame && (linger_r <= 8'd1)) begin
               state_s = ST_BLINK;
            end else begin
               state_s = ST_LANDED;
            end
         end
         ST_BLINK: begin
            if (presentCollected) begin
               state_s = ST_IDLE;
            end else if (startOfFrame && (blink_r <= 8'd1)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BLINK;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Frame counters: loaded on state entry, stepped on startOfFrame while resident
   always_comb begin
      linger_s = linger_r;
      blink_s  = blink_r;
      phase_s  = phase_r;
      case (state_s)
         ST_LANDED: begin
            if (state_r != ST_LANDED) begin
               linger_s = LINGER_C;
            end else if (startOfFrame) begin
               linger_s = linger_r - 8'd1;
            end else begin
               linger_s = linger_r;
            end
         end
         ST_BLINK: begin
            if (state_r != ST_BLINK) begin
               blink_s = BLINK_C;
               phase_s = PERIOD_C;
            end else if (startOfFrame) begin
               blink_s = blink_r - 8'd1;
               if (phase_r <= 8'd1) begin
                  phase_s = PERIOD_C;
               end else begin
                  phase_s = phase_r - 8'd1;
               end
            end else begin
               blink_s = blink_r;
               phase_s = phase_r;
            end
         end
         default: begin
            linger_s = 8'd0;
            blink_s  = 8'd0;
            phase_s  = 8'd0;
         end
      endcase
   end

   // Output decode from the upcoming state so every output is a flop
   always_comb begin
      loadn_s      = 1'b1;
      visible_s    = 1'b0;
      landed_s     = 1'b0;
      busy_s       = (state_s != ST_IDLE);
      collected_s  = alive_s && presentCollected;
      init_x_s     = initialX;
      init_y_s     = initialY;
      init_speed_s = initialYspeed;
      type_s       = presentType;
      case (state_s)
         ST_LOAD: begin
            loadn_s = 1'b0;
         end
         ST_FALLING: begin
            visible_s = 1'b1;
         end
         ST_LANDED: begin
            visible_s = 1'b1;
            landed_s  = 1'b1;
         end
         ST_BLINK: begin
            landed_s = 1'b1;
            if (state_r != ST_BLINK) begin
               visible_s = 1'b1;
            end else if (startOfFrame && (phase_r <= 8'd1)) begin
               visible_s = ~presentVisible;
            end else begin
               visible_s = presentVisible;
            end
         end
         default: begin
            loadn_s   = 1'b1;
            visible_s = 1'b0;
         end
      endcase
      // Spawn parameters change only on an accepted spawn and hold after retirement
      if ((state_r == ST_IDLE) && (state_s == ST_LOAD)) begin
         init_x_s     = (popX > X_MAX) ? X_MAX : popX;
         init_y_s     = (popY > Y_MAX) ? Y_MAX : popY;
         init_speed_s = LIFT_SPEED;
         type_s       = lfsr_r[3:2];
      end else begin
         init_x_s     = initialX;
         init_y_s     = initialY;
         init_speed_s = initialYspeed;
         type_s       = presentType;
      end
   end

   // Output and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         loadN          <= 1'b1;
         initialX       <= 11'd0;
         initialY       <= 11'd0;
         initialYspeed  <= 16'd0;
         presentVisible <= 1'b0;
         presentType    <= 2'd0;
         collectedPulse <= 1'b0;
         landed         <= 1'b0;
         busy           <= 1'b0;
         linger_r       <= 8'd0;
         blink_r        <= 8'd0;
         phase_r        <= 8'd0;
      end else begin
         loadN          <= loadn_s;
         initialX       <= init_x_s;
         initialY       <= init_y_s;
         initialYspeed  <= init_speed_s;
         presentVisible <= visible_s;
         presentType    <= type_s;
         collectedPulse <= collected_s;
         landed         <= landed_s;
         busy           <= busy_s;
         linger_r       <= linger_s;
         blink_r        <= blink_s;
         phase_r        <= phase_s;
      end
   end

endmodule
